decode_and_fetch_operands: RTL and testbench
============================================

# decode_and_fetch_operands

Instruction decode and operand-fetch pipeline stage between the fetch unit and the execute unit. Splits each 16-bit instruction into opcode, register and memory-address fields, and drives register-file read addresses combinationally. Registers the decoded fields, the returned operand values and their in-use (scoreboard) flags for the execute stage.

## Interface
Parameters: none; all widths fixed.

- clk  in  1  — single clock; rising edge active.
- rst  in  1  — asynchronous, active-low reset.
- instr  in  16  — instruction from fetch: [15:12] opcode, [11:0] operand fields.
- srcRegVal1  in  16  — register-file read data for srcReg1.
- srcRegVal2  in  16  — register-file read data for srcReg2.
- inuse1  in  1  — register file: srcReg1 has a pending write.
- inuse2  in  1  — register file: srcReg2 has a pending write.
- srcReg1  out  4  — read address 1 to the register file (combinational).
- srcReg2  out  4  — read address 2 to the register file (combinational).
- nextDestReg  out  4  — destination of the instruction being decoded, to the register file for in-use marking (combinational).
- opcode  out  4  — registered opcode to execute.
- destReg  out  4  — registered destination register.
- srcVal1  out  16  — registered operand 1.
- srcVal2  out  16  — registered operand 2.
- memAddr  out  8  — registered memory address (LOAD/STORE only).
- used1  out  1  — registered copy of inuse1.
- used2  out  1  — registered copy of inuse2.

## Operation
- Format decode on instr[15:12]:
  - LOAD (4'b1110): dest = instr[3:0]; memAddr = instr[11:4]; srcReg1 = srcReg2 = 0.
  - STORE (4'b1111): srcReg1 = instr[3:0] (data register); memAddr = instr[11:4]; srcReg2 = 0; dest = 0.
  - All other opcodes (register format): dest = instr[11:8]; srcReg1 = instr[7:4]; srcReg2 = instr[3:0]; memAddr = 0.
- nextDestReg = decoded dest, combinational from instr.
- The stage registers: opcode = instr[15:12]; destReg = dest; memAddr; srcVal1/srcVal2 = srcRegVal1/srcRegVal2; used1/used2 = inuse1/inuse2.
- No hazard resolution here: used1/used2 are forwarded and execute decides on a stall.
- No opcode is illegal. Unlisted opcodes decode as register format.

## Timing
- srcReg1, srcReg2, nextDestReg: combinational from instr, zero latency. The register file returns srcRegVal*/inuse* in the same cycle.
- opcode, destReg, memAddr, srcVal1, srcVal2, used1, used2: captured on the rising clk edge. One-cycle latency from instr and register-file data.
- Reset (rst = 0): all registered outputs clear to 0 immediately, asynchronously. srcReg1, srcReg2 and nextDestReg are forced to 0 while rst = 0.
- Reset mid-stream: the instruction in decode is dropped. The first capture after rst rises takes the current instr.
- A change to srcRegVal*/inuse* with instr held is recaptured on the next edge.

## Structure
- Shared package: OPC_LOAD = 4'b1110, OPC_STORE = 4'b1111, field-width constants (OPC_W=4, REG_W=4, DATA_W=16, ADDR_W=8).
- One natural sub-module, instr_field_decode: purely combinational; instr -> srcReg1, srcReg2, dest, memAddr, is_load, is_store.
- The top level holds the register bank and the reset muxing.

## Test plan
- Register format: instr=16'b0010_0011_0011_0001, srcRegVal1=40, srcRegVal2=50, inuse=0. Response: srcReg1=3, srcReg2=1, nextDestReg=3 immediately. After the edge: opcode=2, destReg=3, srcVal1=40, srcVal2=50, memAddr=0, used1=used2=0.
- LOAD: instr=16'b1110_0111_1110_1110. Response: nextDestReg=14, srcReg1=srcReg2=0. After the edge: opcode=14, destReg=14, memAddr=8'h7E.
- STORE: instr=16'b1111_0111_1110_1111. Response: srcReg1=15, srcReg2=0, nextDestReg=0. After the edge: opcode=15, memAddr=8'h7E, srcVal1 = srcRegVal1.
- Operand update with instr held: change srcRegVal1 50->80. Response: srcVal1=80 after the next edge; other outputs unchanged.
- Flags: inuse1=1, then inuse2=1 on successive cycles. Response: used1, then used2, rise one edge later.
- Asynchronous reset: drive rst=0 between clock edges. Response: all outputs read 0 before the next edge and stay 0 while rst=0. After release, the first edge captures the current instr.

Source files
------------

// File: rtl/decode_and_fetch_operands_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decode_and_fetch_operands_pkg
//  Purpose  : Shared field widths, opcode constants and the decoded-field
//             record used by the decode / operand-fetch stage.
//  Contents : OPC_W, REG_W, DATA_W, ADDR_W, INSTR_W, OPC_LOAD, OPC_STORE,
//             decoded_t
//  Revision : 1.0  initial release
// ============================================================================
package decode_and_fetch_operands_pkg;

    localparam int OPC_W   = 4;
    localparam int REG_W   = 4;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    localparam logic [OPC_W-1:0] OPC_LOAD  = 4'b1110;
    localparam logic [OPC_W-1:0] OPC_STORE = 4'b1111;

    // Fields pulled out of one instruction by the format decoder.
    typedef struct packed {
        logic [REG_W-1:0]  src_reg1;
        logic [REG_W-1:0]  src_reg2;
        logic [REG_W-1:0]  dest;
        logic [ADDR_W-1:0] mem_addr;
        logic              is_load;
        logic              is_store;
    } decoded_t;

endpackage : decode_and_fetch_operands_pkg
`default_nettype wire

// File: rtl/decode_and_fetch_operands_instr_field_decode.sv
`default_nettype none
// ============================================================================
//  Module   : instr_field_decode
//  Purpose  : Purely combinational format decoder. Splits a 16-bit
//             instruction into register-file read addresses, destination,
//             memory address and LOAD/STORE flags.
//  Ports    : instr    in  16  instruction word
//             fields   out     decoded_t record
//  Revision : 1.0  initial release
// ============================================================================
module instr_field_decode
    import decode_and_fetch_operands_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output decoded_t           fields
);

    logic [OPC_W-1:0] w_opc;

    assign w_opc = instr[15:12];

    always_comb begin
        fields = '0;
        case (w_opc)
            OPC_LOAD: begin
                fields.is_load  = 1'b1;
                fields.dest     = instr[3:0];
                fields.mem_addr = instr[11:4];
            end
            OPC_STORE: begin
                // The data register being stored travels on read port 1.
                fields.is_store = 1'b1;
                fields.src_reg1 = instr[3:0];
                fields.mem_addr = instr[11:4];
            end
            default: begin
                // Every other opcode, listed or not, is register format.
                fields.dest     = instr[11:8];
                fields.src_reg1 = instr[7:4];
                fields.src_reg2 = instr[3:0];
            end
        endcase
    end

endmodule : instr_field_decode
`default_nettype wire

// File: rtl/decode_and_fetch_operands.sv
`default_nettype none
// ============================================================================
//  Module   : decode_and_fetch_operands
//  Purpose  : Decode / operand-fetch pipeline stage. Drives register-file
//             read addresses combinationally and registers the decoded
//             fields, returned operands and in-use flags for execute.
//  Ports    : clk, rst (async, active-low)
//             instr[15:0]                         from fetch
//             srcRegVal1/2[15:0], inuse1/2        from register file
//             srcReg1/2[3:0], nextDestReg[3:0]    to register file (comb)
//             opcode, destReg, srcVal1/2, memAddr,
//             used1/2                             to execute (registered)
//  Revision : 1.0  initial release
// ============================================================================
module decode_and_fetch_operands
    import decode_and_fetch_operands_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [INSTR_W-1:0]  instr,
    input  logic [DATA_W-1:0]   srcRegVal1,
    input  logic [DATA_W-1:0]   srcRegVal2,
    input  logic                inuse1,
    input  logic                inuse2,
    output logic [REG_W-1:0]    srcReg1,
    output logic [REG_W-1:0]    srcReg2,
    output logic [REG_W-1:0]    nextDestReg,
    output logic [OPC_W-1:0]    opcode,
    output logic [REG_W-1:0]    destReg,
    output logic [DATA_W-1:0]   srcVal1,
    output logic [DATA_W-1:0]   srcVal2,
    output logic [ADDR_W-1:0]   memAddr,
    output logic                used1,
    output logic                used2
);

    decoded_t         w_fields;
    logic [ADDR_W-1:0] w_mem_addr;

    instr_field_decode u_decode (
        .instr  (instr),
        .fields (w_fields)
    );

    // Only memory-format instructions carry an address downstream.
    assign w_mem_addr = (w_fields.is_load || w_fields.is_store) ? w_fields.mem_addr : '0;

    // Read addresses and destination are held at zero during reset so the
    // register file sees no spurious reads or in-use marking.
    assign srcReg1     = rst ? w_fields.src_reg1 : '0;
    assign srcReg2     = rst ? w_fields.src_reg2 : '0;
    assign nextDestReg = rst ? w_fields.dest     : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opcode  <= '0;
            destReg <= '0;
            srcVal1 <= '0;
            srcVal2 <= '0;
            memAddr <= '0;
            used1   <= 1'b0;
            used2   <= 1'b0;
        end else begin
            opcode  <= instr[15:12];
            destReg <= w_fields.dest;
            srcVal1 <= srcRegVal1;
            srcVal2 <= srcRegVal2;
            memAddr <= w_mem_addr;
            used1   <= inuse1;
            used2   <= inuse2;
        end
    end

endmodule : decode_and_fetch_operands
`default_nettype wire

// File: tb/tb_decode_and_fetch_operands.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_and_fetch_operands
//  Purpose  : Self-checking bench for decode_and_fetch_operands.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decode_and_fetch_operands;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic [15:0] srcRegVal1, srcRegVal2;
    logic        inuse1, inuse2;
    logic [3:0]  srcReg1, srcReg2, nextDestReg, opcode, destReg;
    logic [15:0] srcVal1, srcVal2;
    logic [7:0]  memAddr;
    logic        used1, used2;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  opc;
        logic [3:0]  dst;
        logic [15:0] v1;
        logic [15:0] v2;
        logic [7:0]  ma;
        logic        u1;
        logic        u2;
    } reg_exp_t;

    reg_exp_t sb[$];

    always #5 clk = ~clk;

    decode_and_fetch_operands dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .srcRegVal1  (srcRegVal1),
        .srcRegVal2  (srcRegVal2),
        .inuse1      (inuse1),
        .inuse2      (inuse2),
        .srcReg1     (srcReg1),
        .srcReg2     (srcReg2),
        .nextDestReg (nextDestReg),
        .opcode      (opcode),
        .destReg     (destReg),
        .srcVal1     (srcVal1),
        .srcVal2     (srcVal2),
        .memAddr     (memAddr),
        .used1       (used1),
        .used2       (used2)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode written from the instruction format table.
    task automatic ref_decode(input logic [15:0] ins, output logic [3:0] s1,
                              output logic [3:0] s2, output logic [3:0] d,
                              output logic [7:0] ma);
        if (ins[15:12] == 4'hE) begin
            s1 = 0; s2 = 0; d = ins[3:0]; ma = ins[11:4];
        end else if (ins[15:12] == 4'hF) begin
            s1 = ins[3:0]; s2 = 0; d = 0; ma = ins[11:4];
        end else begin
            s1 = ins[7:4]; s2 = ins[3:0]; d = ins[11:8]; ma = 0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_srcReg1"},  {12'h0, srcReg1},     16'h0);
        check({tag, "_srcReg2"},  {12'h0, srcReg2},     16'h0);
        check({tag, "_nextDest"}, {12'h0, nextDestReg}, 16'h0);
        check({tag, "_opcode"},   {12'h0, opcode},      16'h0);
        check({tag, "_destReg"},  {12'h0, destReg},     16'h0);
        check({tag, "_srcVal1"},  srcVal1,              16'h0);
        check({tag, "_srcVal2"},  srcVal2,              16'h0);
        check({tag, "_memAddr"},  {8'h0, memAddr},      16'h0);
        check({tag, "_used1"},    {15'h0, used1},       16'h0);
        check({tag, "_used2"},    {15'h0, used2},       16'h0);
    endtask

    // Drive one instruction at the falling edge, check the combinational
    // read addresses, push the registered expectation, then pop and compare
    // it just after the next rising edge.
    task automatic step(input logic [15:0] ins, input logic [15:0] a,
                        input logic [15:0] b, input logic f1, input logic f2);
        logic [3:0] s1, s2, d;
        logic [7:0] ma;
        reg_exp_t   e, got;
        instr = ins; srcRegVal1 = a; srcRegVal2 = b; inuse1 = f1; inuse2 = f2;
        ref_decode(ins, s1, s2, d, ma);
        #1;
        check("comb_srcReg1",  {12'h0, srcReg1},     {12'h0, s1});
        check("comb_srcReg2",  {12'h0, srcReg2},     {12'h0, s2});
        check("comb_nextDest", {12'h0, nextDestReg}, {12'h0, d});
        e = '{opc: ins[15:12], dst: d, v1: a, v2: b, ma: ma, u1: f1, u2: f2};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            got = '{opc: opcode, dst: destReg, v1: srcVal1, v2: srcVal2,
                    ma: memAddr, u1: used1, u2: used2};
            check("reg_opcode",  {12'h0, got.opc}, {12'h0, e.opc});
            check("reg_destReg", {12'h0, got.dst}, {12'h0, e.dst});
            check("reg_srcVal1", got.v1,           e.v1);
            check("reg_srcVal2", got.v2,           e.v2);
            check("reg_memAddr", {8'h0, got.ma},   {8'h0, e.ma});
            check("reg_used1",   {15'h0, got.u1},  {15'h0, e.u1});
            check("reg_used2",   {15'h0, got.u2},  {15'h0, e.u2});
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        instr = 16'h2331; srcRegVal1 = 16'd9; srcRegVal2 = 16'd7;
        inuse1 = 1'b1; inuse2 = 1'b1;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Register format, directed constants from the test plan.
        instr = 16'b0010_0011_0011_0001; srcRegVal1 = 16'd40; srcRegVal2 = 16'd50;
        inuse1 = 0; inuse2 = 0;
        #1;
        check("tp_reg_srcReg1",  {12'h0, srcReg1},     16'd3);
        check("tp_reg_srcReg2",  {12'h0, srcReg2},     16'd1);
        check("tp_reg_nextDest", {12'h0, nextDestReg}, 16'd3);
        @(posedge clk); #1;
        check("tp_reg_opcode",  {12'h0, opcode},  16'd2);
        check("tp_reg_destReg", {12'h0, destReg}, 16'd3);
        check("tp_reg_srcVal1", srcVal1,          16'd40);
        check("tp_reg_srcVal2", srcVal2,          16'd50);
        check("tp_reg_memAddr", {8'h0, memAddr},  16'd0);
        @(negedge clk);

        // LOAD and STORE formats.
        step(16'b1110_0111_1110_1110, 16'd40, 16'd50, 0, 0);
        check("tp_load_memAddr", {8'h0, memAddr}, 16'h007E);
        check("tp_load_destReg", {12'h0, destReg}, 16'd14);
        step(16'b1111_0111_1110_1111, 16'h1234, 16'h5678, 0, 0);
        check("tp_store_opcode", {12'h0, opcode}, 16'd15);
        check("tp_store_srcVal1", srcVal1, 16'h1234);

        // Operand update with instruction held.
        step(16'h2331, 16'd50, 16'd60, 0, 0);
        step(16'h2331, 16'd80, 16'd60, 0, 0);
        check("tp_update_srcVal1", srcVal1, 16'd80);

        // In-use flags rising on successive cycles.
        step(16'h2331, 16'd80, 16'd60, 1, 0);
        step(16'h2331, 16'd80, 16'd60, 1, 1);

        // Every opcode, including unlisted ones, plus random fields.
        for (int i = 0; i < 16; i++) begin
            logic [15:0] ins;
            ins = {i[3:0], 12'($urandom)};
            step(ins, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end

        // Make sure registered outputs are non-zero before asserting reset.
        step(16'h9ABC, 16'hBEEF, 16'hCAFE, 1, 1);

        // Asynchronous reset mid-cycle: instruction in decode is dropped.
        instr = 16'h5678; srcRegVal1 = 16'h1111; srcRegVal2 = 16'h2222;
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk); #1;
        check_all_zero("rst_held");
        @(negedge clk);
        rst = 1'b1;
        step(16'h3AB4, 16'h0F0F, 16'hF0F0, 0, 1);
        check("post_rst_opcode", {12'h0, opcode}, 16'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net against a stalled simulation.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_decode_and_fetch_operands
`default_nettype wire
